// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet FCS receive controller
//
// Purpose: FSM state and error-code enums, CRC constants and frame length
// limits shared by eth_fcs_ctrl and crc32_nibble_step.
// Ports: none (package).

package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CRC  = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_ODD  = 2'd3
  } err_e;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  // Register contents after data plus a correct (complemented) FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam logic [11:0] MIN_NIBBLES = 12'd128;
  localparam logic [11:0] MAX_NIBBLES = 12'd3036;
  localparam logic [11:0] NIB_CNT_MAX = 12'hFFF;
  localparam logic [15:0] STAT_MAX    = 16'hFFFF;

endpackage

// File: rtl/crc32_nibble_step.sv
// rtl/crc32_nibble_step.sv - combinational CRC-32 advance by one received nibble
//
// Purpose: advance an MSB-first CRC-32 register (poly 0x04C11DB7) by four bits.
// Ports:
//   crc_in  [31:0] in   current register value
//   d       [3:0]  in   received nibble, d[0] is the first bit on the wire
//   crc_out [31:0] out  register after the four bits

module crc32_nibble_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Feeding d[0] first is the same as shifting {d[0],d[1],d[2],d[3]} in
  // MSB-first, i.e. the bit-reversed nibble.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (c[31] ^ d[i]) begin
        c = {c[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_fcs_ctrl.sv
// rtl/eth_fcs_ctrl.sv - RMII-style nibble receiver with preamble strip, FCS check and statistics
//
// Purpose: strips preamble/SFD, forwards payload+FCS nibbles, checks CRC,
// length and nibble parity at end of frame and keeps saturating counters.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   rxd[3:0]   in   receive nibble, bit0 first on wire
//   crs_dv     in   carrier/data valid, qualified by rx_strobe
//   rx_strobe  in   one-clk pulse per received nibble
//   axiod[3:0] out  forwarded nibble
//   axiov      out  axiod valid
//   frame_done out  end-of-frame pulse
//   frame_ok   out  frame good (with frame_done)
//   err_code   out  0 none, 1 CRC, 2 length, 3 odd nibble count
//   good_cnt   out  saturating good-frame count
//   bad_cnt    out  saturating bad-frame count

module eth_fcs_ctrl
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rxd,
  input  logic        crs_dv,
  input  logic        rx_strobe,
  output logic [3:0]  axiod,
  output logic        axiov,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0]  axiod_q, axiod_d;
  logic        axiov_q, axiov_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  err_e        err_q, err_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  logic [31:0] crc_next;
  err_e        err_sel;
  logic        start_step;

  crc32_nibble_step u_crc_step (
    .crc_in  (crc_q),
    .d       (rxd),
    .crc_out (crc_next)
  );

  // A step that would open a preamble from IDLE; also used in DRAIN so a
  // frame starting right after the previous one loses nothing.
  assign start_step = rx_strobe && crs_dv && (rxd == 4'h5);

  always_comb begin
    err_sel = ERR_NONE;
    if (cnt_q[0]) begin
      err_sel = ERR_ODD;
    end else if ((cnt_q < MIN_NIBBLES) || (cnt_q > MAX_NIBBLES)) begin
      err_sel = ERR_LEN;
    end else if (crc_q != CRC_RESIDUE) begin
      err_sel = ERR_CRC;
    end
  end

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    axiod_d      = axiod_q;
    axiov_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_d        = err_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_step) begin
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (rx_strobe) begin
          if (crs_dv && (rxd == 4'h5)) begin
            state_d = ST_PREAMBLE;
          end else if (crs_dv && (rxd == 4'hD)) begin
            state_d = ST_DATA;
            crc_d   = CRC_INIT;
            cnt_d   = 12'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (rx_strobe) begin
          if (crs_dv) begin
            crc_d   = crc_next;
            axiod_d = rxd;
            axiov_d = 1'b1;
            if (cnt_q != NIB_CNT_MAX) begin
              cnt_d = cnt_q + 12'd1;
            end
          end else begin
            // The carrier-drop nibble carries no data and is not consumed.
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        frame_done_d = 1'b1;
        err_d        = err_sel;
        frame_ok_d   = (err_sel == ERR_NONE);
        if (err_sel == ERR_NONE) begin
          if (good_cnt_q != STAT_MAX) begin
            good_cnt_d = good_cnt_q + 16'd1;
          end
        end else begin
          if (bad_cnt_q != STAT_MAX) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end
        state_d = start_step ? ST_PREAMBLE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= 12'd0;
      axiod_q      <= 4'd0;
      axiov_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_q        <= ERR_NONE;
      good_cnt_q   <= 16'd0;
      bad_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      axiod_q      <= axiod_d;
      axiov_q      <= axiov_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_q        <= err_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign axiod      = axiod_q;
  assign axiov      = axiov_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_code   = err_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_eth_fcs_ctrl.sv
// tb/tb_eth_fcs_ctrl.sv - directed self-checking bench for eth_fcs_ctrl

module tb_eth_fcs_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rxd;
  logic        crs_dv;
  logic        rx_strobe;
  logic [3:0]  axiod;
  logic        axiov;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] nib [0:4095];
  int         nnib;

  logic [3:0] cap [0:8191];
  int         ax_cnt   = 0;
  int         done_cnt = 0;
  int         ok_cnt   = 0;
  logic       last_ok;
  logic [1:0] last_err;

  logic first_axiov;
  logic [3:0] first_axiod;
  logic gap_axiov;

  eth_fcs_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .crs_dv     (crs_dv),
    .rx_strobe  (rx_strobe),
    .axiod      (axiod),
    .axiov      (axiov),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_code   (err_code),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (axiov) begin
      cap[ax_cnt % 8192] = axiod;
      ax_cnt = ax_cnt + 1;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      if (frame_ok) ok_cnt = ok_cnt + 1;
      last_ok  = frame_ok;
      last_err = err_code;
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d, input logic stb);
    crs_dv    = dv;
    rxd       = d;
    rx_strobe = stb;
    @(posedge clk);
    #1;
  endtask

  // Payload bytes, then reflected CRC-32 complemented, low byte first,
  // each byte low nibble first.
  task automatic build_frame(input int npay, input int seed);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    nnib = 0;
    for (int i = 0; i < npay; i++) begin
      b = 8'((i * 7 + seed) & 255);
      nib[nnib] = b[3:0];
      nib[nnib + 1] = b[7:4];
      nnib = nnib + 2;
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    fcs = ~c;
    for (int j = 0; j < 4; j++) begin
      b = fcs[8*j +: 8];
      nib[nnib] = b[3:0];
      nib[nnib + 1] = b[7:4];
      nnib = nnib + 2;
    end
  endtask

  task automatic send_frame(input int npre, input bit gap, input bit tail);
    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5, 1'b1);
    drive(1'b1, 4'hD, 1'b1);
    for (int i = 0; i < nnib; i++) begin
      drive(1'b1, nib[i], 1'b1);
      if (i == 0) begin
        first_axiov = axiov;
        first_axiod = axiod;
      end
      if (gap) begin
        drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        if (i == 0) gap_axiov = axiov;
      end
    end
    drive(1'b0, 4'h0, 1'b1);
    if (tail) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'h5, 1'b1);
    drive(1'b1, 4'h5, 1'b1);
    n_vec++; if (axiov !== 1'b0) begin n_err++; $display("FAIL reset_axiov: got %b want 0", axiov); end
    n_vec++; if (axiod !== 4'h0) begin n_err++; $display("FAIL reset_axiod: got %h want 0", axiod); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_vec++; if (frame_ok !== 1'b0) begin n_err++; $display("FAIL reset_frame_ok: got %b want 0", frame_ok); end
    n_vec++; if (err_code !== 2'd0) begin n_err++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_vec++; if (good_cnt !== 16'd0) begin n_err++; $display("FAIL reset_good_cnt: got %h want 0", good_cnt); end
    n_vec++; if (bad_cnt !== 16'd0) begin n_err++; $display("FAIL reset_bad_cnt: got %h want 0", bad_cnt); end
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_good_frame();
    int ax0, dn0, bad_nib;
    ax0 = ax_cnt; dn0 = done_cnt;
    build_frame(60, 3);
    send_frame(15, 1'b1, 1'b1);
    n_vec++; if (ax_cnt - ax0 !== 128) begin n_err++; $display("FAIL good_axiov_count: got %0d want 128", ax_cnt - ax0); end
    bad_nib = -1;
    for (int i = 0; i < 128; i++) if (bad_nib < 0 && cap[(ax0 + i) % 8192] !== nib[i]) bad_nib = i;
    n_vec++; if (bad_nib !== -1) begin n_err++; $display("FAIL good_axiod_stream: first wrong nibble %0d got %h want %h", bad_nib, cap[(ax0 + bad_nib) % 8192], nib[bad_nib]); end
    n_vec++; if (first_axiov !== 1'b1 || first_axiod !== nib[0]) begin n_err++; $display("FAIL good_latency: got v=%b d=%h want v=1 d=%h", first_axiov, first_axiod, nib[0]); end
    n_vec++; if (gap_axiov !== 1'b0) begin n_err++; $display("FAIL good_gap_hold: got axiov=%b want 0", gap_axiov); end
    n_vec++; if (done_cnt - dn0 !== 1) begin n_err++; $display("FAIL good_frame_done: got %0d pulses want 1", done_cnt - dn0); end
    n_vec++; if (last_ok !== 1'b1 || last_err !== 2'd0) begin n_err++; $display("FAIL good_status: got ok=%b err=%0d want ok=1 err=0", last_ok, last_err); end
    n_vec++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin n_err++; $display("FAIL good_counters: got good=%0d bad=%0d want 1/0", good_cnt, bad_cnt); end
  endtask

  task automatic test_crc_error();
    int dn0;
    dn0 = done_cnt;
    build_frame(60, 3);
    nib[10] = nib[10] ^ 4'h2;
    send_frame(15, 1'b0, 1'b1);
    n_vec++; if (done_cnt - dn0 !== 1) begin n_err++; $display("FAIL crc_frame_done: got %0d pulses want 1", done_cnt - dn0); end
    n_vec++; if (last_ok !== 1'b0 || last_err !== 2'd1) begin n_err++; $display("FAIL crc_status: got ok=%b err=%0d want ok=0 err=1", last_ok, last_err); end
    n_vec++; if (bad_cnt !== 16'd1 || good_cnt !== 16'd1) begin n_err++; $display("FAIL crc_counters: got good=%0d bad=%0d want 1/1", good_cnt, bad_cnt); end
  endtask

  task automatic test_length();
    build_frame(59, 11);
    send_frame(15, 1'b0, 1'b1);
    n_vec++; if (last_ok !== 1'b0 || last_err !== 2'd2) begin n_err++; $display("FAIL runt_status: got ok=%b err=%0d want ok=0 err=2", last_ok, last_err); end
    n_vec++; if (bad_cnt !== 16'd2) begin n_err++; $display("FAIL runt_bad_cnt: got %0d want 2", bad_cnt); end
    build_frame(59, 11);
    nib[nnib] = 4'h3;
    nnib = nnib + 1;
    send_frame(15, 1'b0, 1'b1);
    n_vec++; if (last_ok !== 1'b0 || last_err !== 2'd3) begin n_err++; $display("FAIL odd_status: got ok=%b err=%0d want ok=0 err=3", last_ok, last_err); end
    n_vec++; if (bad_cnt !== 16'd3 || good_cnt !== 16'd1) begin n_err++; $display("FAIL odd_counters: got good=%0d bad=%0d want 1/3", good_cnt, bad_cnt); end
  endtask

  task automatic test_bad_preamble();
    int ax0, dn0;
    ax0 = ax_cnt; dn0 = done_cnt;
    drive(1'b1, 4'h5, 1'b1);
    drive(1'b1, 4'h5, 1'b1);
    drive(1'b1, 4'h3, 1'b1);
    drive(1'b1, 4'hD, 1'b1);
    drive(1'b1, 4'h1, 1'b1);
    drive(1'b1, 4'h2, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1);
    n_vec++; if (ax_cnt - ax0 !== 0) begin n_err++; $display("FAIL badpre_axiov: got %0d pulses want 0", ax_cnt - ax0); end
    n_vec++; if (done_cnt - dn0 !== 0) begin n_err++; $display("FAIL badpre_frame_done: got %0d pulses want 0", done_cnt - dn0); end
    n_vec++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd3) begin n_err++; $display("FAIL badpre_counters: got good=%0d bad=%0d want 1/3", good_cnt, bad_cnt); end
  endtask

  task automatic test_reset_midframe();
    int dn0;
    build_frame(60, 5);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b1);
    drive(1'b1, 4'hD, 1'b1);
    for (int i = 0; i < 50; i++) drive(1'b1, nib[i], 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    dn0 = done_cnt;
    n_vec++; if (axiov !== 1'b0 || axiod !== 4'h0) begin n_err++; $display("FAIL midrst_axi: got v=%b d=%h want v=0 d=0", axiov, axiod); end
    n_vec++; if (frame_ok !== 1'b0 || err_code !== 2'd0 || frame_done !== 1'b0) begin n_err++; $display("FAIL midrst_status: got done=%b ok=%b err=%0d want 0/0/0", frame_done, frame_ok, err_code); end
    n_vec++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_counters: got good=%0d bad=%0d want 0/0", good_cnt, bad_cnt); end
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0, 1'b1);
    n_vec++; if (done_cnt - dn0 !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - dn0); end
    build_frame(60, 9);
    send_frame(15, 1'b0, 1'b1);
    n_vec++; if (good_cnt !== 16'd1 || last_ok !== 1'b1) begin n_err++; $display("FAIL midrst_next_frame: got good=%0d ok=%b want 1/1", good_cnt, last_ok); end
  endtask

  task automatic test_back_to_back();
    int ax0, dn0, ok0;
    force dut.good_cnt_q = 16'hFFFF;
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    release dut.good_cnt_q;
    drive(1'b0, 4'h0, 1'b0);
    n_vec++; if (good_cnt !== 16'hFFFF) begin n_err++; $display("FAIL b2b_preset: got %h want ffff", good_cnt); end
    ax0 = ax_cnt; dn0 = done_cnt; ok0 = ok_cnt;
    build_frame(60, 21);
    send_frame(15, 1'b0, 1'b0);
    // Second frame has a single preamble nibble, which lands in the DRAIN cycle.
    send_frame(1, 1'b0, 1'b1);
    n_vec++; if (done_cnt - dn0 !== 2 || ok_cnt - ok0 !== 2) begin n_err++; $display("FAIL b2b_ok_pulses: got done=%0d ok=%0d want 2/2", done_cnt - dn0, ok_cnt - ok0); end
    n_vec++; if (ax_cnt - ax0 !== 256) begin n_err++; $display("FAIL b2b_axiov_count: got %0d want 256", ax_cnt - ax0); end
    n_vec++; if (good_cnt !== 16'hFFFF || bad_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_saturate: got good=%h bad=%0d want ffff/0", good_cnt, bad_cnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    rxd       = 4'h0;
    crs_dv    = 1'b0;
    rx_strobe = 1'b0;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length();
    test_bad_preamble();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_fcs_ctrl.md
ETH_FCS_CTRL -- requirements
Module: eth_fcs_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port rxd  input  4  receive nibble, bit0 first on wire.
REQ-004 SHALL have port crs_dv  input  1  carrier/data valid, sampled only with rx_strobe.
REQ-005 SHALL have port rx_strobe  input  1  one-clk pulse per received nibble.
REQ-006 SHALL have port axiod  output  4  payload nibble (preamble/SFD stripped, FCS included).
REQ-007 SHALL have port axiov  output  1  axiod valid, one clk per accepted nibble.
REQ-008 SHALL have port frame_done  output  1  one-clk pulse at end of frame.
REQ-009 SHALL have port frame_ok  output  1  valid with frame_done: CRC good, length legal, even nibble count.
REQ-010 SHALL have port err_code  output  2  valid with frame_done: 0 none, 1 CRC, 2 runt/giant, 3 odd nibble.
REQ-011 SHALL have ports good_cnt, bad_cnt  output  16 each  saturating frame statistics.

Function
REQ-012 SHALL act only on clk cycles with rx_strobe=1 (a "step"); other cycles hold all state.
REQ-013 SHALL implement FSM IDLE, PREAMBLE, DATA, DRAIN.
REQ-014 IDLE: step with crs_dv=1 and rxd=4'h5 -> PREAMBLE; any other step stays IDLE.
REQ-015 PREAMBLE: step rxd=4'h5 stays; rxd=4'hD -> DATA with CRC register set to 32'hFFFFFFFF and nibble counter cleared; any other value or crs_dv=0 -> IDLE (no output, no frame_done).
REQ-016 DATA: step with crs_dv=1 -> CRC advanced by one nibble, axiod=rxd, axiov=1 next clk, nibble counter +1 (12-bit, saturates at 4095).
REQ-017 DATA: step with crs_dv=0 -> DRAIN; that nibble is not consumed.
REQ-018 DRAIN: next clk asserts frame_done with frame_ok/err_code, updates one counter, -> IDLE.
REQ-019 CRC step SHALL use polynomial 0x04C11DB7, MSB-first register form, nibble applied bit-reversed ({rxd[0],rxd[1],rxd[2],rxd[3]}).
REQ-020 CRC good SHALL mean register equals 32'hC704DD7B after the last nibble (data plus FCS).
REQ-021 Error priority: odd nibble count (3) > length outside 128..3036 nibbles (2) > CRC (1).
REQ-022 frame_ok=1 iff err_code=0; good_cnt or bad_cnt increments, each saturating at 16'hFFFF.
REQ-023 Latency: axiod/axiov registered, exactly one clk after the consuming step.
REQ-024 A step coinciding with DRAIN SHALL be handled as an IDLE step (back-to-back frames, no loss).

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, CRC 32'hFFFFFFFF, counter 0, axiov=0, axiod=0, frame_done=0, frame_ok=0, err_code=0, good_cnt=0, bad_cnt=0.
REQ-026 Reset mid-frame SHALL discard the frame with no frame_done and no counter update.

Structure
REQ-027 Shared package eth_pkg SHALL hold FSM state enum, err_code enum, CRC_INIT, CRC_RESIDUE, MIN_NIBBLES=128, MAX_NIBBLES=3036.
REQ-028 SHALL instantiate one sub-module crc32_nibble_step: purely combinational, (crc_in[31:0], d[3:0]) -> crc_out[31:0].
REQ-029 FSM, counters and output registers SHALL reside in eth_fcs_ctrl; no clock-domain crossings.

Verification
REQ-030 15x 4'h5, 4'hD, 60-byte payload plus correct FCS (128 nibbles) -> 128 axiov pulses, frame_done with frame_ok=1, err_code=0, good_cnt=1.
REQ-031 Same frame, one payload bit flipped -> frame_ok=0, err_code=1, bad_cnt=1.
REQ-032 63-byte frame with correct FCS (126 nibbles) -> err_code=2; 127 nibbles -> err_code=3.
REQ-033 Preamble 4'h5,4'h5,4'h3 -> return to IDLE, no axiov, no frame_done, counters unchanged.
REQ-034 rst_n=0 for one clk at nibble 50 of a valid frame -> all outputs reset values, no frame_done; next valid frame -> good_cnt=1.
REQ-035 Two valid frames, second preamble's first step in DRAIN cycle, and good_cnt preset to 16'hFFFF -> two frame_ok pulses, good_cnt holds 16'hFFFF.
